// File: rtl/data_memory_pkg.sv
// Shared load/store size encodings and the byte-enable type for the data memory.
package data_memory_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [3:0] byte_en_t;

endpackage

// File: rtl/dmem_load_ext.sv
// Load path: picks the byte/halfword lane out of a stored word and sign- or zero-extends it.
module dmem_load_ext
  import data_memory_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Extend the selected lane according to the access size and signedness
  always_comb begin
    o_result = i_word;
    case (i_funct3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'h000000, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'h0000, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory: combinational loads, synchronous stores.
// Optional macro DMEM_MISALIGN_CHECK_EN adds the misaligned output and suppresses misaligned accesses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  input  logic                  writeEnable,
  input  logic [2:0]            funct3,
  output logic [31:0]           readData
`ifdef DMEM_MISALIGN_CHECK_EN
  ,
  output logic                  misaligned
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  byte_en_t         w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_ext;
  logic             w_mis;
  logic             w_unused;

  // Upper address bits alias onto the array
  assign w_idx    = address[IDX_W+1:2];
  assign w_off    = address[1:0];
  assign w_unused = ^address[ADDR_WIDTH-1:IDX_W+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  // Detect halfword/word accesses that are not naturally aligned
  always_comb begin
    w_mis = 1'b0;
    if (((funct3 == F3_H) || (funct3 == F3_HU)) && w_off[0]) begin
      w_mis = 1'b1;
    end else if ((funct3 == F3_W) && (w_off != 2'b00)) begin
      w_mis = 1'b1;
    end else begin
      w_mis = 1'b0;
    end
  end
  assign misaligned = w_mis;
`else
  assign w_mis = 1'b0;
`endif

  // Byte enables and lane-replicated store data; unknown store sizes act as sw
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = writeData;
    case (funct3)
      F3_B: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{writeData[7:0]}};
      end
      F3_H: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{writeData[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = writeData;
      end
    endcase
  end

  // Storage array: async clear, lane-masked synchronous writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'h00000000;
      end
    end else if (writeEnable && !w_mis) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) begin
          r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
        end
      end
    end
  end

  dmem_load_ext u_load_ext (
    .i_word   (r_mem[w_idx]),
    .i_offset (w_off),
    .i_funct3 (funct3),
    .o_result (w_ext)
  );

  assign readData = (!rst || w_mis) ? 32'h00000000 : w_ext;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: expected load results are queued and compared against readData.
module tb_data_memory;

  localparam int DEPTH_WORDS = 64;
  localparam int ADDR_WIDTH  = 32;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [ADDR_WIDTH-1:0] address = 32'h0;
  logic [31:0]           writeData = 32'h0;
  logic                  writeEnable = 1'b0;
  logic [2:0]            funct3 = 3'b010;
  logic [31:0]           readData;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic                  misaligned;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rd_exp;

  always #5 clk = ~clk;

  data_memory #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .address     (address),
    .writeData   (writeData),
    .writeEnable (writeEnable),
    .funct3      (funct3),
    .readData    (readData)
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    .misaligned  (misaligned)
`endif
  );

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    address = a; writeData = d; funct3 = f; writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] a [2];
    a[0] = 32'd0; a[1] = 32'd4;
    #1 rst = 1'b0;
    #10 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      address = a[i]; funct3 = W;
      exp_q.push_back(32'h00000000);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL reset_lw@%0d: got %08h want %08h", a[i], readData, rd_exp);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] a [2];
    logic [31:0] e [2];
    do_store(32'd0, 32'h12345678, W);
    do_store(32'd4, 32'hABCDEF01, W);
    a[0] = 32'd0; e[0] = 32'h12345678;
    a[1] = 32'd4; e[1] = 32'hABCDEF01;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      address = a[i]; funct3 = W;
      exp_q.push_back(e[i]);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL word_lw@%0d: got %08h want %08h", a[i], readData, rd_exp);
      end
    end
  endtask

  task automatic test_byte();
    logic [31:0] a [4];
    logic [2:0]  f [4];
    logic [31:0] e [4];
    do_store(32'd1, 32'h000000FF, B);
    a[0] = 32'd0; f[0] = W;  e[0] = 32'h1234FF78;
    a[1] = 32'd1; f[1] = B;  e[1] = 32'hFFFFFFFF;
    a[2] = 32'd1; f[2] = BU; e[2] = 32'h000000FF;
    a[3] = 32'd3; f[3] = B;  e[3] = 32'h00000012;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = a[i]; funct3 = f[i];
      exp_q.push_back(e[i]);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL byte_%0d@%0d: got %08h want %08h", i, a[i], readData, rd_exp);
      end
    end
  endtask

  task automatic test_half();
    logic [31:0] a [5];
    logic [2:0]  f [5];
    logic [31:0] e [5];
    a[0] = 32'd6; f[0] = H;  e[0] = 32'hFFFFABCD;
    a[1] = 32'd6; f[1] = HU; e[1] = 32'h0000ABCD;
    a[2] = 32'd4; f[2] = W;  e[2] = 32'hABCD5555;
    a[3] = 32'd4; f[3] = H;  e[3] = 32'h00005555;
    a[4] = 32'd8; f[4] = W;  e[4] = 32'hCAFEBABE;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        do_store(32'd4, 32'hFFFF5555, H);
        do_store(32'd8, 32'hCAFEBABE, 3'b011);
      end
      @(negedge clk);
      address = a[i]; funct3 = f[i];
      exp_q.push_back(e[i]);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL half_%0d@%0d: got %08h want %08h", i, a[i], readData, rd_exp);
      end
    end
  endtask

  task automatic test_wrap_nowrite();
    logic [31:0] a [4];
    logic [2:0]  f [4];
    logic [31:0] e [4];
    @(negedge clk);
    address = 32'd0; writeData = 32'hDEADBEEF; funct3 = W; writeEnable = 1'b0;
    @(negedge clk);
    a[0] = DEPTH_WORDS * 4;  f[0] = W; e[0] = 32'h1234FF78;
    a[1] = 32'hFFFFFF00;     f[1] = W; e[1] = 32'h1234FF78;
    a[2] = 32'd0;            f[2] = W; e[2] = 32'h1234FF78;
`ifdef DMEM_MISALIGN_CHECK_EN
    a[3] = 32'd3;            f[3] = W; e[3] = 32'h00000000;
`else
    a[3] = 32'd3;            f[3] = W; e[3] = 32'h1234FF78;
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = a[i]; funct3 = f[i];
      exp_q.push_back(e[i]);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL wrap_%0d@%08h: got %08h want %08h", i, a[i], readData, rd_exp);
      end
    end
  endtask

  task automatic test_rdw();
    @(negedge clk);
    address = 32'd12; funct3 = W; writeData = 32'h11223344; writeEnable = 1'b1;
    exp_q.push_back(32'h00000000);
    #1;
    rd_exp = exp_q.pop_front();
    checks++;
    if (readData !== rd_exp) begin
      errors++;
      $display("FAIL rdw_before: got %08h want %08h", readData, rd_exp);
    end
    @(posedge clk);
    exp_q.push_back(32'h11223344);
    #1;
    rd_exp = exp_q.pop_front();
    checks++;
    if (readData !== rd_exp) begin
      errors++;
      $display("FAIL rdw_after: got %08h want %08h", readData, rd_exp);
    end
    writeEnable = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    address = 32'd0; funct3 = W; writeData = 32'hFFFFFFFF; writeEnable = 1'b1;
    rst = 1'b0;
    exp_q.push_back(32'h00000000);
    #1;
    rd_exp = exp_q.pop_front();
    checks++;
    if (readData !== rd_exp) begin
      errors++;
      $display("FAIL midreset_now: got %08h want %08h", readData, rd_exp);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    writeEnable = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      address = 32'(i * 4);
      exp_q.push_back(32'h00000000);
      #1;
      rd_exp = exp_q.pop_front();
      checks++;
      if (readData !== rd_exp) begin
        errors++;
        $display("FAIL midreset_cleared@%0d: got %08h want %08h", i * 4, readData, rd_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap_nowrite();
    test_rdw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable data memory for the single-cycle RISC-V core; sits between the ALU address path and the writeback mux.
- Reads are combinational; writes are synchronous on the rising clock edge.
- Supports RV32I load/store sizes via funct3: byte, halfword and word accesses, with sign or zero extension on loads.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored (256 bytes); must be a power of two.
- ADDR_WIDTH, 32, width of the address port.

Ports:
- clk  input  1  system clock; writes occur on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- address  input  ADDR_WIDTH  byte address.
- writeData  input  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- writeEnable  input  1  store strobe, sampled at the rising edge of clk.
- funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu; tie to 010 for word-only use.
- readData  output  32  load result, combinational.

Behaviour:
- Storage is DEPTH_WORDS x 32, little-endian. Word index = address[log2(DEPTH_WORDS)+1:2]; byte offset = address[1:0]. Upper address bits are ignored, so addresses alias (wrap) modulo DEPTH_WORDS*4.
- Reset: while rst is low, every word is cleared to 0 asynchronously, readData evaluates to 0, and writes are blocked. Reset asserted during a write cycle wins and no write occurs.
- Write: at posedge clk with rst high and writeEnable=1, update only the addressed lanes:
  - sb writes writeData[7:0] to the lane selected by offset.
  - sh writes writeData[15:0] to lanes {address[1],0}..+1.
  - sw writes all four lanes.
  - funct3 011/100/101/110/111 on a store is treated as sw.
- Read: readData is a pure function of the current address, funct3 and array contents (zero latency).
  - lb/lbu select the byte at the offset, then sign-/zero-extend.
  - lh/lhu select the halfword at address[1], then sign-/zero-extend.
  - lw and any other funct3 return the full word.
- Misalignment without the check (default): the halfword ignores address[0]; the word ignores address[1:0].
- Read-during-write to the same address: readData shows old contents until the edge, then new contents combinationally after it. No bypass.
- writeEnable=0 never modifies memory.

Optional Feature:
- Macro DMEM_MISALIGN_CHECK_EN.
- When defined: adds output port misaligned (1 bit, combinational).
  - misaligned=1 for a halfword access with address[0]=1, or a word access with address[1:0]!=0.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load returns 0.
- When undefined: the port is absent and the low-bit masking above applies.

Decomposition:
- Package data_memory_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - A 4-bit byte-enable type.
- One sub-module, dmem_load_ext: combinational lane select plus sign/zero extension (inputs: word, offset, funct3; output: 32-bit result).
- Byte-enable generation stays in the top module.

Test Plan:
- Reset: rst=0 for 10 ns, then read addresses 0 and 4 with lw -> readData=0x00000000 both.
- Word write/read: sw 0x12345678 @0, sw 0xABCDEF01 @4 (writeEnable=1, one edge each), then writeEnable=0 -> lw @0 = 0x12345678, lw @4 = 0xABCDEF01.
- Byte store: after the word writes, sb 0xFF @1 -> lw @0 = 0x1234FF78; lb @1 = 0xFFFFFFFF; lbu @1 = 0x000000FF.
- Halfword: lh @6 on word 0xABCDEF01 -> 0xFFFFABCD; lhu @6 -> 0x0000ABCD; sh 0x5555 @4 -> lw @4 = 0xABCD5555.
- Wrap and no-write: lw @(DEPTH_WORDS*4) equals lw @0. A cycle with writeEnable=0 and new writeData leaves contents unchanged. Asserting rst mid-sequence immediately gives readData=0 with no clock edge required.
